// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA-3 core control path.
//   ROUNDS    : number of Keccak-f[1600] rounds, also the one-hot round index width.
//   state_t   : 2-bit encoding of the round controller FSM (IDLE / ROUND / WAIT_OUT).
package sha3_pkg;

  localparam int ROUNDS = 24;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t ROUND    = 2'd1;
  localparam state_t WAIT_OUT = 2'd2;

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// Handshake and control bundle between the padder, the round controller,
// the state datapath and the digest consumer.
//   slave  : the round controller (takes blocks and out_ready, drives the controls).
//   master : the surrounding core / testbench (presents blocks and accepts the digest).
//   blk_valid/blk_last/blk_ready : block handshake from the padder.
//   absorb/round_en/round_onehot  : datapath and round-constant controls.
//   busy/out_valid/out_ready/state_clr : status and digest handshake.
interface keccak_round_ctrl_if;
  import sha3_pkg::*;

  logic              blk_valid;
  logic              blk_last;
  logic              blk_ready;
  logic              absorb;
  logic              round_en;
  logic [ROUNDS-1:0] round_onehot;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic              state_clr;

  modport slave (
    input  blk_valid, blk_last, out_ready,
    output blk_ready, absorb, round_en, round_onehot, busy, out_valid, state_clr
  );

  modport master (
    output blk_valid, blk_last, out_ready,
    input  blk_ready, absorb, round_en, round_onehot, busy, out_valid, state_clr
  );

endinterface

// File: rtl/keccak_round_counter.sv
// One-hot round index ring.
//   clk, reset : clock and synchronous active-high reset.
//   load       : start a permutation, index becomes bit 0.
//   clr        : force the index to all-zero (end of permutation).
//   shift      : advance to the next round.
//   onehot     : current round index, all-zero when no permutation is running.
//   last       : the final round is being applied this cycle.
module keccak_round_counter #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic         shift,
  output logic [N-1:0] onehot,
  output logic         last
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clr)
      onehot <= '0;
    else if (load)
      onehot <= {{(N-1){1'b0}}, 1'b1};
    else if (shift)
      onehot <= {onehot[N-2:0], 1'b0};
  end

  assign last = onehot[N-1];

endmodule

// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] round sequencer for the low-throughput SHA-3 core.
// Takes one padded block per handshake, runs ROUNDS rounds one per cycle,
// then either returns for the next block or, after the final block, holds
// out_valid until the consumer accepts the digest.
//   clk, reset : clock and synchronous active-high reset.
//   bus        : keccak_round_ctrl_if slave modport (handshakes and datapath controls).
module keccak_round_ctrl
  import sha3_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  keccak_round_ctrl_if.slave   bus
);

  state_t            state_q;
  state_t            state_d;
  logic              last_q;
  logic              out_valid_q;
  logic [ROUNDS-1:0] onehot;
  logic              last_round;

  logic blk_ready;
  logic absorb;
  logic round_en;
  logic state_clr;
  logic perm_done;

  keccak_round_counter #(.N(ROUNDS)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (absorb),
    .clr    (perm_done),
    .shift  (round_en),
    .onehot (onehot),
    .last   (last_round)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every variable in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (absorb)    state_d = ROUND;
      ROUND:    if (last_round) state_d = last_q ? WAIT_OUT : IDLE;
      WAIT_OUT: if (state_clr) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output decode. Gating with reset keeps every control quiet during the
  // reset cycle even while the state register still holds its old value.
  always_comb begin
    blk_ready = 1'b0;
    round_en  = 1'b0;
    state_clr = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:     blk_ready = 1'b1;
        ROUND:    round_en  = 1'b1;
        WAIT_OUT: state_clr = bus.out_ready;
        default:  ;
      endcase
    end
  end

  assign absorb    = bus.blk_valid & blk_ready;
  assign perm_done = round_en & last_round;

  // Message-final flag captured with the block, and the registered digest flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (absorb)
        last_q <= bus.blk_last;
      if (perm_done && last_q)
        out_valid_q <= 1'b1;
      else if (state_clr)
        out_valid_q <= 1'b0;
    end
  end

  assign bus.blk_ready    = blk_ready;
  assign bus.absorb       = absorb;
  assign bus.round_en     = round_en;
  assign bus.busy         = round_en;
  assign bus.round_onehot = onehot;
  assign bus.out_valid    = out_valid_q;
  assign bus.state_clr    = state_clr;

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
- Sequences the Keccak-f[1600] permutation for the low-throughput SHA-3 core.
- Accepts padded blocks from the padder through a valid/ready handshake and runs 24 rounds, one per cycle.
- Drives the one-hot round index into the round-constant generator and the round-enable/absorb controls of the state datapath.
- Holds the digest-valid indication until the consumer accepts it.

Parameters:
- ROUNDS, 24, number of permutation rounds; also the width of the one-hot round index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- blk_valid  input  1  padder presents a full block.
- blk_last  input  1  qualifies blk_valid: the block is the final block of the message.
- blk_ready  output  1  controller can accept a block.
- absorb  output  1  datapath XORs the block into the state this cycle.
- round_en  output  1  datapath applies one round this cycle.
- round_onehot  output  ROUNDS  one-hot round index to the round-constant generator; all-zero when idle.
- busy  output  1  a permutation is in progress.
- out_valid  output  1  digest is valid in the state register.
- out_ready  input  1  consumer accepts the digest.
- state_clr  output  1  one-cycle pulse; datapath zeroes the state for the next message.

Behaviour:
- States: IDLE, ROUND, WAIT_OUT. Reset → IDLE.
- Reset values:
  - round_onehot = 0, last_q = 0.
  - out_valid, busy, round_en, absorb, state_clr all 0.
  - blk_ready = 0 while reset is high.
- blk_ready = (state==IDLE) & ~reset, combinational.
- absorb = blk_valid & blk_ready, combinational. This is the only cycle in which a block is taken.

IDLE:
- On absorb: last_q <= blk_last, round_onehot <= 1 (bit 0), go to ROUND.
- blk_valid while not in IDLE is ignored. The padder must hold the block stable until blk_ready.

ROUND:
- round_en = 1, busy = 1.
- Each cycle round_onehot shifts left by one.
- In the cycle where round_onehot[ROUNDS-1] = 1 (the last round is applied), the next state is chosen:
  - last_q = 1: go to WAIT_OUT, round_onehot <= 0, out_valid <= 1.
  - last_q = 0: go to IDLE, round_onehot <= 0.
- Exactly ROUNDS cycles with round_en = 1 per block.
- Latency: block accepted at edge T → rounds in cycles T+1..T+24 → out_valid from T+25 (final block), or blk_ready again at T+25 (non-final block).

WAIT_OUT:
- out_valid held at 1 (registered) and busy = 0.
- On out_ready: out_valid <= 0, state_clr pulses for one cycle, go to IDLE.
- blk_ready = 0 in this state. blk_valid together with out_ready is not accepted until the next (IDLE) cycle.

General rules:
- out_ready while out_valid = 0: ignored.
- Reset asserted mid-ROUND or mid-WAIT_OUT: at the next edge the state is IDLE with all outputs at reset values; no state_clr pulse. The datapath is reset by the same signal.
- Invariants:
  - round_onehot is zero or one-hot.
  - round_onehot is non-zero iff state==ROUND.
  - absorb and round_en are never both high.

Decomposition:
- sha3_pkg holds:
  - ROUNDS = 24.
  - State encoding localparams IDLE / ROUND / WAIT_OUT (2 bits).
- One natural sub-module, keccak_round_counter: a one-hot shift ring with load, clear and a last-round flag. It is instantiated once; the FSM stays in keccak_round_ctrl.

Test Plan:
- Single final block: blk_valid=blk_last=1 at cycle 0.
  - absorb=1 at cycle 0.
  - round_onehot = 1<<k in cycle 1+k (k = 0..23).
  - out_valid=1 from cycle 25.
  - With out_ready=1 at cycle 27: state_clr=1 at 27, blk_ready=1 at 28.
- Two-block message: first blk_last=0, second blk_last=1, both valid continuously.
  - Second absorb at cycle 25.
  - out_valid rises at cycle 50.
  - 48 round_en cycles in total.
- Backpressure: out_ready low for 10 cycles after out_valid.
  - out_valid stays 1, blk_ready stays 0, no state_clr until out_ready.
- blk_valid held high throughout ROUND: no extra absorb; round_onehot is unaffected.
- Reset at cycle 12 of ROUND: next cycle round_onehot=0, busy=0, blk_ready=1 after reset is released, no out_valid.
- Simultaneous out_ready and blk_valid in WAIT_OUT: block absorbed exactly one cycle after state_clr, never in the same cycle.
